// File: rtl/executs_md_pkg.sv
`default_nettype none
// ============================================================================
// executs_md_pkg : shared op encodings, FSM states and default width for the
//                  multiply/divide unit.  Rev 1.0
// ============================================================================
package executs_md_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/executs_md.sv
`default_nettype none
// ============================================================================
// executs_md : iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//              One bit per cycle, WIDTH+1 edges from start to done. Rev 1.0
// ============================================================================
module executs_md
    import executs_md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    md_state_t        state;
    md_state_t        state_nxt;

    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic             dz_flag;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             in_signed;
    logic             in_div;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != ST_IDLE);

    // Operand conditioning at acceptance; a zero divisor keeps the raw
    // dividend so the remainder comes out as operand_a unsigned-corrected.
    always_comb begin
        in_signed = md_is_signed(op);
        in_div    = md_is_div(op);
        a_neg     = in_signed & operand_a[WIDTH-1];
        b_neg     = in_signed & operand_b[WIDTH-1];
        b_zero    = in_div & (operand_b == '0);
        mag_a_in  = (a_neg && !b_zero) ? -operand_a : operand_a;
        mag_b_in  = b_neg ? -operand_b : operand_b;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
        div_diff = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, mag_b};
        div_ok   = ~|div_diff[WIDTH+1:WIDTH];
        prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix  = neg_q ? -acc_lo : acc_lo;
        rem_fix  = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: if (cnt == LAST_STEP) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_flag  <= 1'b0;
            cnt      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_div  <= in_div;
                        neg_q   <= !b_zero && (a_neg ^ b_neg);
                        neg_r   <= !b_zero && in_div && a_neg;
                        dz_flag <= b_zero;
                        cnt     <= '0;
                        mag_a   <= mag_a_in;
                        mag_b   <= mag_b_in;
                        acc_hi  <= '0;
                        acc_lo  <= in_div ? mag_a_in : mag_b_in;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        // Restoring step: quotient bits enter at the bottom of acc_lo.
                        acc_hi <= div_ok ? div_diff[WIDTH-1:0]
                                         : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    if (op_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done     <= 1'b1;
                    div_zero <= dz_flag;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
